seq_divider: RTL and testbench
==============================

Name: seq_divider

Overview:
- Sequential unsigned restoring divider; the inverse of the array multiplier built from the FA cells in comb/multiplier.
- Produces one quotient bit per clock.
- Uses a start/busy/done handshake so it can share a datapath with the multiplier in the arithmetic unit.
- Computes quotient and remainder of WIDTH-bit operands in WIDTH cycles; divide-by-zero is flagged and short-circuited.

Parameters:
WIDTH, 8, operand/quotient/remainder width in bits (>=2)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
start  input  1  request; sampled on rising clk, accepted only when busy==0
in_A  input  WIDTH  dividend, sampled on accepted start
in_B  input  WIDTH  divisor, sampled on accepted start
out_Q  output  WIDTH  quotient, registered
out_R  output  WIDTH  remainder, registered
busy  output  1  high while a division is in progress
done  output  1  single-cycle pulse: out_Q/out_R/div_zero valid
div_zero  output  1  registered; set with done when divisor was 0

Behaviour:
- Reset (async, active-high): state=IDLE; out_Q, out_R, busy, done, div_zero, counter and internal regs all 0. Deassertion is sampled by clk.
- States: IDLE, CALC, DONE.
- IDLE / DONE, start=1, in_B!=0:
  - load dividend reg=in_A, divisor reg=in_B, partial remainder (WIDTH+1 bits)=0, count=WIDTH-1.
  - go CALC; busy=1, done=0.
- IDLE / DONE, start=1, in_B==0:
  - go DONE next edge; out_Q=all ones, out_R=in_A, div_zero=1, done=1, busy stays 0.
- DONE with start=0: go IDLE; done returns to 0.
- Outputs hold their values until overwritten by the next completion.
- CALC, each edge:
  - P' = {P[WIDTH-1:0], dividend MSB}; shift dividend left 1.
  - If P' >= divisor: P = P' - divisor and quotient LSB=1; else P = P' and quotient LSB=0 (restoring).
  - Subtraction is WIDTH+1 bits wide, so no overflow.
- count==0 in CALC: that edge performs the final iteration, loads out_Q=quotient and out_R=P[WIDTH-1:0], sets div_zero=0, goes DONE (done=1, busy=0); otherwise count decrements.
- Latency: start accepted at edge k -> done high during the cycle after edge k+WIDTH (WIDTH iterations). Divide-by-zero: done high after edge k.
- Back-to-back operation:
  - start with busy==1 is ignored; operands are not re-sampled.
  - start in the DONE cycle is accepted, so back-to-back throughput is one result per WIDTH+1 cycles.
- in_A/in_B may change freely after the accepting edge.
- Reset mid-CALC aborts immediately; no done pulse; outputs read 0.
- done is never high in two consecutive cycles unless a div-by-zero start is accepted in the DONE cycle.
- Invariant on every non-div_zero done: out_Q*in_B + out_R == in_A and out_R < in_B.

Test Plan:
1. WIDTH=8, in_A=100, in_B=7, start 1 cycle:
   - busy high 8 cycles, then done pulse.
   - out_Q=14, out_R=2, div_zero=0.
2. Boundaries:
   - 255/1 -> Q=255, R=0.
   - 5/9 -> Q=0, R=5.
   - 0/3 -> Q=0, R=0.
   - 255/255 -> Q=1, R=0.
   - Each takes exactly 8 cycles.
3. in_A=37, in_B=0:
   - done in the cycle after accept, busy never high.
   - Q=0xFF, R=37, div_zero=1.
   - A following 37/5 clears div_zero: Q=7, R=2.
4. Start accepted for 200/9; pulse start with 50/5 at cycle 3 of CALC:
   - second request ignored.
   - result Q=22, R=2.
   - Then start in the DONE cycle with 50/5 -> accepted, Q=10, R=0 after 8 more cycles.
5. Assert rst at cycle 4 of CALC for 123/4:
   - outputs, busy and done go 0 asynchronously; no done pulse.
   - Next 123/4 gives Q=30, R=3.
6. Random 1000 operand pairs (divisor != 0):
   - Q*B+R==A and R<B.
   - Latency exactly WIDTH cycles.
   - done is a one-cycle pulse.

Source files
------------

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider.
// One quotient bit per clock with a start/busy/done handshake.
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in_A,
  input  logic [WIDTH-1:0] in_B,
  output logic [WIDTH-1:0] out_Q,
  output logic [WIDTH-1:0] out_R,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] p;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   p_sh;
  logic [WIDTH-1:0] sub;
  logic             ge;
  logic [WIDTH-1:0] p_nx;
  logic [WIDTH-1:0] q_nx;
  logic             b_zero;

  assign b_zero = (in_B == '0);

  // P < divisor holds between steps, so a WIDTH-bit difference is exact.
  assign p_sh = {p, dvd[WIDTH-1]};
  assign ge   = (p_sh >= {1'b0, dvs});
  assign sub  = p_sh[WIDTH-1:0] - dvs;
  assign p_nx = ge ? sub : p_sh[WIDTH-1:0];
  assign q_nx = {dvd[WIDTH-2:0], ge};

  assign busy = (state == CALC);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start) state_nx = b_zero ? DONE : CALC;
      end
      CALC: begin
        if (cnt == '0) state_nx = DONE;
      end
      DONE: begin
        if (start) state_nx = b_zero ? DONE : CALC;
        else       state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Quotient bits shift into the dividend register as it empties.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvd      <= '0;
      dvs      <= '0;
      p        <= '0;
      cnt      <= '0;
      out_Q    <= '0;
      out_R    <= '0;
      div_zero <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            if (!b_zero) begin
              dvd <= in_A;
              dvs <= in_B;
              p   <= '0;
              cnt <= CW'(WIDTH - 1);
            end else begin
              out_Q    <= '1;
              out_R    <= in_A;
              div_zero <= 1'b1;
            end
          end
        end
        CALC: begin
          dvd <= q_nx;
          p   <= p_nx;
          if (cnt == '0) begin
            out_Q    <= q_nx;
            out_R    <= p_nx;
            div_zero <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed and random checks for seq_divider.
// Inputs change and outputs are sampled on the falling edge.
module tb_seq_divider;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] in_A;
  logic [7:0] in_B;
  logic [7:0] out_Q;
  logic [7:0] out_R;
  logic       busy;
  logic       done;
  logic       div_zero;

  int checks;
  int errors;

  seq_divider #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_A     (in_A),
    .in_B     (in_B),
    .out_Q    (out_Q),
    .out_R    (out_R),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic start_now(input logic [7:0] a, input logic [7:0] b);
    start = 1'b1;
    in_A  = a;
    in_B  = b;
    @(negedge clk);
    start = 1'b0;
    in_A  = 8'hxx;
    in_B  = 8'hxx;
  endtask

  task automatic do_start(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    start_now(a, b);
  endtask

  task automatic wait_done(output int n, output int nb);
    n  = 0;
    nb = 0;
    while (!done && n < 40) begin
      if (busy) nb++;
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset;
    rst   = 1'b1;
    start = 1'b0;
    in_A  = 8'd0;
    in_B  = 8'd0;
    repeat (2) @(negedge clk);
    checks++;
    if ({out_Q, out_R, busy, done, div_zero} !== 19'd0) begin
      errors++;
      $display("FAIL reset: Q=%0d R=%0d busy=%b done=%b dz=%b, want all 0",
               out_Q, out_R, busy, done, div_zero);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int n, nb;
    do_start(8'd100, 8'd7);
    wait_done(n, nb);
    checks++;
    if (n !== 8 || nb !== 8) begin
      errors++;
      $display("FAIL basic_latency: cycles=%0d busy=%0d, want 8/8", n, nb);
    end
    checks++;
    if (out_Q !== 8'd14 || out_R !== 8'd2 || div_zero !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_result: Q=%0d R=%0d dz=%b busy=%b, want 14 2 0 0",
               out_Q, out_R, div_zero, busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL basic_pulse: done=%b, want 0", done);
    end
  endtask

  task automatic test_boundaries;
    logic [7:0] va [5] = '{8'd255, 8'd5, 8'd0, 8'd255, 8'd200};
    logic [7:0] vb [5] = '{8'd1,   8'd9, 8'd3, 8'd255, 8'd128};
    logic [7:0] vq [5] = '{8'd255, 8'd0, 8'd0, 8'd1,   8'd1};
    logic [7:0] vr [5] = '{8'd0,   8'd5, 8'd0, 8'd0,   8'd72};
    int n, nb;
    for (int i = 0; i < 5; i++) begin
      do_start(va[i], vb[i]);
      wait_done(n, nb);
      checks++;
      if (n !== 8 || out_Q !== vq[i] || out_R !== vr[i] || div_zero !== 1'b0) begin
        errors++;
        $display("FAIL bound_%0d: %0d/%0d cyc=%0d Q=%0d R=%0d dz=%b, want 8 %0d %0d 0",
                 i, va[i], vb[i], n, out_Q, out_R, div_zero, vq[i], vr[i]);
      end
    end
  endtask

  task automatic test_div_zero;
    int n, nb;
    do_start(8'd37, 8'd0);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL dz_timing: done=%b busy=%b, want 1 0", done, busy);
    end
    checks++;
    if (out_Q !== 8'hFF || out_R !== 8'd37 || div_zero !== 1'b1) begin
      errors++;
      $display("FAIL dz_result: Q=%0h R=%0d dz=%b, want ff 37 1",
               out_Q, out_R, div_zero);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || out_Q !== 8'hFF || div_zero !== 1'b1) begin
      errors++;
      $display("FAIL dz_hold: done=%b busy=%b Q=%0h dz=%b, want 0 0 ff 1",
               done, busy, out_Q, div_zero);
    end
    do_start(8'd37, 8'd5);
    wait_done(n, nb);
    checks++;
    if (n !== 8 || out_Q !== 8'd7 || out_R !== 8'd2 || div_zero !== 1'b0) begin
      errors++;
      $display("FAIL dz_clear: cyc=%0d Q=%0d R=%0d dz=%b, want 8 7 2 0",
               n, out_Q, out_R, div_zero);
    end
  endtask

  task automatic test_back_to_back;
    int n, nb;
    do_start(8'd200, 8'd9);
    @(negedge clk);
    @(negedge clk);
    start_now(8'd50, 8'd5);
    wait_done(n, nb);
    checks++;
    if (n !== 5 || out_Q !== 8'd22 || out_R !== 8'd2) begin
      errors++;
      $display("FAIL b2b_ignore: cyc=%0d Q=%0d R=%0d, want 5 22 2", n, out_Q, out_R);
    end
    start_now(8'd50, 8'd5);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept: busy=%b done=%b, want 1 0", busy, done);
    end
    wait_done(n, nb);
    checks++;
    if (n !== 8 || out_Q !== 8'd10 || out_R !== 8'd0) begin
      errors++;
      $display("FAIL b2b_result: cyc=%0d Q=%0d R=%0d, want 8 10 0", n, out_Q, out_R);
    end
  endtask

  task automatic test_dz_in_done;
    do_start(8'd9, 8'd0);
    start_now(8'd77, 8'd0);
    checks++;
    if (done !== 1'b1 || out_R !== 8'd77 || div_zero !== 1'b1) begin
      errors++;
      $display("FAIL dz_repeat: done=%b R=%0d dz=%b, want 1 77 1", done, out_R, div_zero);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int n, nb;
    int seen;
    do_start(8'd123, 8'd4);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({out_Q, out_R, busy, done, div_zero} !== 19'd0) begin
      errors++;
      $display("FAIL rst_async: Q=%0d R=%0d busy=%b done=%b dz=%b, want all 0",
               out_Q, out_R, busy, done, div_zero);
    end
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL rst_abort: active cycles=%0d, want 0", seen);
    end
    do_start(8'd123, 8'd4);
    wait_done(n, nb);
    checks++;
    if (n !== 8 || out_Q !== 8'd30 || out_R !== 8'd3) begin
      errors++;
      $display("FAIL rst_redo: cyc=%0d Q=%0d R=%0d, want 8 30 3", n, out_Q, out_R);
    end
  endtask

  task automatic test_random;
    logic [7:0] a, b, eq, er;
    int n, nb;
    for (int i = 0; i < 1000; i++) begin
      a  = 8'($urandom_range(255, 0));
      b  = 8'($urandom_range(255, 1));
      eq = a / b;
      er = a % b;
      do_start(a, b);
      wait_done(n, nb);
      checks++;
      if (n !== 8 || out_Q !== eq || out_R !== er || div_zero !== 1'b0) begin
        errors++;
        $display("FAIL rand_%0d: %0d/%0d cyc=%0d Q=%0d R=%0d, want 8 %0d %0d",
                 i, a, b, n, out_Q, out_R, eq, er);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL rand_pulse_%0d: done=%b, want 0", i, done);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset;
    test_basic;
    test_boundaries;
    test_div_zero;
    test_back_to_back;
    test_dz_in_done;
    test_reset_mid;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
